hamming_secded_link: RTL and testbench
======================================

Name: hamming_secded_link

Overview:
- Parametrised successor to the team's 8-bit Hamming encode/correct/display block.
- Encodes DATA_W-bit words into extended Hamming (SECDED) codewords and optionally injects 0/1/2-bit errors.
- Decodes, corrects single errors and flags double errors, then routes each result to one of N_CH channel holding registers.
- Sits between the message source and the per-channel display/consumer logic, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 8, payload width (≥4).
- N_CH, 2, number of destination channels (≥1).
- CNT_W, 8, width of saturating error counters.
- Derived (localparam, not overridable): P = smallest integer with 2^P ≥ DATA_W+P+1; N_CW = DATA_W+P+1 codeword bits (13 for DATA_W=8).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  DATA_W  payload.
- in_ch  in  $clog2(N_CH) (min 1)  destination channel.
- inj_mode  in  2  00 none, 01 single at inj_pos, 10 double at inj_pos and (inj_pos+1) mod N_CW, 11 single at free-running position.
- inj_pos  in  $clog2(N_CW)  injection bit index.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  corrected payload (raw payload if double error).
- out_ch  out  same as in_ch  channel of result.
- out_sbe  out  1  single-bit error corrected.
- out_dbe  out  1  uncorrectable (double) error.
- out_syndrome  out  P  Hamming syndrome.
- ch_data  out  N_CH*DATA_W  channel holding registers, channel k at bits [k*DATA_W +: DATA_W].
- corr_cnt  out  CNT_W  corrected-error count, saturating.
- uncorr_cnt  out  CNT_W  double-error count, saturating.

Behaviour:
- Codeword layout: index 0 = overall parity. Indices 1..N_CW-1 = Hamming positions; powers of two are parity bits. Data bits fill the remaining positions in ascending order, LSB first (DATA_W=8: positions 3,5,6,7,9,10,11,12).
- Parity bit 2^j = XOR of all positions with bit j set. Overall parity = XOR of bits 1..N_CW-1.
- Pipeline, 3 stages, latency 3 cycles from input handshake to out_valid with no stall:
  - S0: encode and inject.
  - S1: syndrome plus overall-parity check.
  - S2: correct and extract.
- Each stage holds a valid bit and advances when the next stage is empty or advancing. in_ready = !s0_valid | s0_advance. out_valid = s2_valid.
- Back-pressure: out_ready low stalls the pipeline with no loss, duplication or reordering. A held output stays stable until out_ready is high.
- Injection:
  - inj_mode and inj_pos are sampled at the input handshake.
  - inj_pos ≥ N_CW suppresses injection.
  - Mode 11 uses a position counter that increments every clk, wraps from N_CW-1 to 0, and resets to 0.
- Decode, with s = syndrome and p = overall parity of all N_CW bits:
  - s=0, p=0: clean.
  - p=1, s=0: overall parity bit in error; sbe=1, data unchanged.
  - p=1, 0<s<N_CW: flip bit s; sbe=1.
  - p=1, s≥N_CW: dbe=1.
  - s≠0, p=0: dbe=1, payload passed uncorrected.
- On output handshake:
  - ch_data[out_ch] ← out_data unless out_dbe=1, in which case that channel retains its value.
  - out_ch ≥ N_CH: no channel written.
  - corr_cnt increments on sbe; uncorr_cnt increments on dbe. Both saturate at 2^CNT_W-1.
- Reset (asynchronous):
  - All valid bits, out_* fields, ch_data, both counters and the position counter are cleared to 0; in_ready=1 on the first cycle after release.
  - In-flight words are discarded.
  - Outputs never drive X.

Decomposition:
- Package hamming_pkg holds:
  - injection-mode enum: INJ_NONE, INJ_SINGLE, INJ_DOUBLE, INJ_FREE;
  - constant function for P from DATA_W;
  - function is_pow2.
- Sub-module hamming_secded_codec: purely combinational encode(data)→codeword and decode(codeword)→{data, syndrome, sbe, dbe}, parametrised by DATA_W. It is reused by the display path.

Test Plan:
- in_data=0xA5, ch=0, mode 00 → out_data=0xA5, sbe=0, dbe=0, syndrome=0 exactly 3 cycles after handshake; ch_data[7:0]=0xA5.
- 0x3C, ch=1, mode 01, pos=5 → out_data=0x3C, sbe=1, syndrome=5, corr_cnt=1, ch_data[15:8]=0x3C.
- ch 0 holding 0xA5, then 0x3C, ch=0, mode 10, pos=3 → dbe=1, ch_data[7:0] stays 0xA5, uncorr_cnt=1; mode 10, pos=12 wraps to bits 12 and 0 → dbe=1.
- 0xFF, mode 01, pos=0 → sbe=1, syndrome=0, out_data=0xFF; pos=13 → no injection, clean.
- out_ready low for 6 cycles while driving 5 back-to-back words → 3 accepted, then in_ready=0; after release all words emerge in order, unaltered.
- CNT_W=2, 5 single-error words → corr_cnt saturates at 3. Assert reset mid-stream → out_valid=0, counters=0, ch_data=0 immediately.

Source files
------------

// File: rtl/hamming_secded_link_pkg.sv
// hamming_pkg: shared types and helpers for the SECDED link.
//   inj_mode_e : error-injection mode encoding
//   calc_p     : number of Hamming parity bits for a payload width
//   is_pow2    : true for parity positions of the Hamming code
//   data_pos   : codeword position of payload bit k (ascending non-power-of-two slots)
package hamming_pkg;

  typedef enum logic [1:0] {
    INJ_NONE   = 2'b00,
    INJ_SINGLE = 2'b01,
    INJ_DOUBLE = 2'b10,
    INJ_FREE   = 2'b11
  } inj_mode_e;

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int unsigned calc_p(input int unsigned data_w);
    int unsigned p;
    p = 1;
    for (int unsigned i = 1; i < 31; i++) begin
      if ((32'd1 << p) < data_w + p + 1) p = p + 1;
    end
    return p;
  endfunction

  function automatic bit is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  // Position k-th payload bit occupies; it can never lie beyond k + 40 for any 32-bit p.
  function automatic int unsigned data_pos(input int unsigned k);
    int unsigned n;
    int unsigned pos;
    n   = 0;
    pos = 0;
    for (int unsigned i = 1; i <= k + 40; i++) begin
      if (!is_pow2(i) && pos == 0) begin
        if (n == k) pos = i;
        n = n + 1;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_link_if.sv
// Handshake bundle of the SECDED link.
//   source side : in_valid/in_ready, in_data, in_ch, inj_mode, inj_pos
//   result side : out_valid/out_ready, out_data, out_ch, out_sbe, out_dbe, out_syndrome
//   master = producer/consumer environment, slave = the link.
interface hamming_secded_link_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CH   = 2
);
  import hamming_pkg::*;

  localparam int unsigned P     = calc_p(DATA_W);
  localparam int unsigned N_CW  = DATA_W + P + 1;
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned POS_W = $clog2(N_CW);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CH_W-1:0]   in_ch;
  logic [1:0]        inj_mode;
  logic [POS_W-1:0]  inj_pos;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_sbe;
  logic              out_dbe;
  logic [P-1:0]      out_syndrome;

  modport master (
    output in_valid, in_data, in_ch, inj_mode, inj_pos, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_sbe, out_dbe, out_syndrome
  );

  modport slave (
    input  in_valid, in_data, in_ch, inj_mode, inj_pos, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_sbe, out_dbe, out_syndrome
  );

endinterface

// File: rtl/hamming_secded_link_codec.sv
// hamming_secded_codec: combinational extended-Hamming encoder/decoder.
//   enc_data -> enc_cw                           : encode
//   chk_cw   -> chk_syndrome, chk_parity         : syndrome and overall parity
//   fix_cw, fix_syndrome, fix_parity
//            -> fix_data, fix_sbe, fix_dbe       : correction and payload extraction
// Wiring chk_* into fix_* of one instance gives a single-cycle full decode;
// the link pipeline feeds them from different stages.
module hamming_secded_codec
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0]                 enc_data,
  output logic [DATA_W+calc_p(DATA_W):0]    enc_cw,
  input  logic [DATA_W+calc_p(DATA_W):0]    chk_cw,
  output logic [calc_p(DATA_W)-1:0]         chk_syndrome,
  output logic                              chk_parity,
  input  logic [DATA_W+calc_p(DATA_W):0]    fix_cw,
  input  logic [calc_p(DATA_W)-1:0]         fix_syndrome,
  input  logic                              fix_parity,
  output logic [DATA_W-1:0]                 fix_data,
  output logic                              fix_sbe,
  output logic                              fix_dbe
);

  localparam int unsigned P    = calc_p(DATA_W);
  localparam int unsigned N_CW = DATA_W + P + 1;

  logic [N_CW-1:0] cw;
  logic [N_CW-1:0] fixed;
  logic            hit;

  // Encode: scatter payload, fill Hamming parity, then overall parity at index 0.
  always_comb begin
    logic par;
    cw  = '0;
    par = 1'b0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      cw[data_pos(k)] = enc_data[k];
    end
    for (int unsigned j = 0; j < P; j++) begin
      par = 1'b0;
      for (int unsigned i = 1; i < N_CW; i++) begin
        if (((i >> j) & 1) == 1 && !is_pow2(i)) par = par ^ cw[i];
      end
      cw[32'd1 << j] = par;
    end
    cw[0] = ^cw[N_CW-1:1];
  end

  assign enc_cw = cw;

  // Syndrome is the XOR of the indices of all set Hamming positions.
  always_comb begin
    chk_syndrome = '0;
    for (int unsigned i = 1; i < N_CW; i++) begin
      if (chk_cw[i]) chk_syndrome = chk_syndrome ^ P'(i);
    end
    chk_parity = ^chk_cw;
  end

  // A nonzero syndrome is only correctable when overall parity also failed
  // and the syndrome names an existing position.
  always_comb begin
    fixed    = fix_cw;
    hit      = 1'b0;
    fix_data = '0;
    for (int unsigned i = 1; i < N_CW; i++) begin
      if (fix_parity && fix_syndrome == P'(i)) begin
        fixed[i] = ~fix_cw[i];
        hit      = 1'b1;
      end
    end
    fix_sbe = fix_parity && (hit || fix_syndrome == '0);
    fix_dbe = (fix_syndrome != '0) && !hit;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      fix_data[k] = fixed[data_pos(k)];
    end
  end

endmodule

// File: rtl/hamming_secded_link.sv
// hamming_secded_link: 3-stage SECDED encode / inject / decode pipeline with
// per-channel holding registers and saturating error counters.
//   clk, reset  : clock, asynchronous active-high reset
//   bus         : slave side of hamming_secded_link_if (input and result handshakes)
//   ch_data     : channel holding registers, channel k at [k*DATA_W +: DATA_W]
//   corr_cnt    : corrected single-error count (saturating)
//   uncorr_cnt  : uncorrectable double-error count (saturating)
module hamming_secded_link
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CH   = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  hamming_secded_link_if.slave     bus,
  output logic [N_CH*DATA_W-1:0]   ch_data,
  output logic [CNT_W-1:0]         corr_cnt,
  output logic [CNT_W-1:0]         uncorr_cnt
);

  localparam int unsigned P     = calc_p(DATA_W);
  localparam int unsigned N_CW  = DATA_W + P + 1;
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned POS_W = $clog2(N_CW);

  logic [POS_W-1:0] free_pos;
  logic [POS_W-1:0] inj_sel;
  logic [POS_W-1:0] inj_next;
  logic             inj_on;
  logic             inj_two;
  logic [N_CW-1:0]  inj_mask;

  logic [N_CW-1:0]  enc_cw;
  logic [P-1:0]     chk_syn;
  logic             chk_par;
  logic [DATA_W-1:0] fix_data;
  logic             fix_sbe;
  logic             fix_dbe;

  logic             s0_valid;
  logic [N_CW-1:0]  s0_cw;
  logic [CH_W-1:0]  s0_ch;
  logic             s1_valid;
  logic [N_CW-1:0]  s1_cw;
  logic [P-1:0]     s1_syn;
  logic             s1_par;
  logic [CH_W-1:0]  s1_ch;
  logic             s2_valid;

  logic in_hs;
  logic out_hs;
  logic s2_space;
  logic s1_adv;
  logic s1_space;
  logic s0_adv;

  // Pipeline flow control: a stage moves when its successor is empty or moving.
  assign out_hs        = s2_valid & bus.out_ready;
  assign s2_space      = !s2_valid | bus.out_ready;
  assign s1_adv        = s1_valid & s2_space;
  assign s1_space      = !s1_valid | s1_adv;
  assign s0_adv        = s0_valid & s1_space;
  assign bus.in_ready  = !s0_valid | s0_adv;
  assign in_hs         = bus.in_valid & bus.in_ready;
  assign bus.out_valid = s2_valid;

  // Free-running injection position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_pos <= '0;
    end else if (free_pos == POS_W'(N_CW - 1)) begin
      free_pos <= '0;
    end else begin
      free_pos <= free_pos + POS_W'(1);
    end
  end

  // Error mask for the word being accepted; out-of-range positions inject nothing.
  always_comb begin
    inj_sel  = bus.inj_pos;
    inj_on   = 1'b0;
    inj_two  = 1'b0;
    inj_mask = '0;
    case (inj_mode_e'(bus.inj_mode))
      INJ_SINGLE: inj_on = 1'b1;
      INJ_DOUBLE: begin
        inj_on  = 1'b1;
        inj_two = 1'b1;
      end
      INJ_FREE: begin
        inj_on  = 1'b1;
        inj_sel = free_pos;
      end
      default: inj_on = 1'b0;
    endcase
    inj_next = (inj_sel == POS_W'(N_CW - 1)) ? '0 : inj_sel + POS_W'(1);
    if (inj_on && 32'(inj_sel) < N_CW) begin
      for (int unsigned i = 0; i < N_CW; i++) begin
        if (inj_sel == POS_W'(i) || (inj_two && inj_next == POS_W'(i))) inj_mask[i] = 1'b1;
      end
    end
  end

  hamming_secded_codec #(
    .DATA_W (DATA_W)
  ) u_codec (
    .enc_data     (bus.in_data),
    .enc_cw       (enc_cw),
    .chk_cw       (s0_cw),
    .chk_syndrome (chk_syn),
    .chk_parity   (chk_par),
    .fix_cw       (s1_cw),
    .fix_syndrome (s1_syn),
    .fix_parity   (s1_par),
    .fix_data     (fix_data),
    .fix_sbe      (fix_sbe),
    .fix_dbe      (fix_dbe)
  );

  // S0: encoded and possibly corrupted codeword.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s0_cw    <= '0;
      s0_ch    <= '0;
    end else if (in_hs) begin
      s0_valid <= 1'b1;
      s0_cw    <= enc_cw ^ inj_mask;
      s0_ch    <= bus.in_ch;
    end else if (s0_adv) begin
      s0_valid <= 1'b0;
    end
  end

  // S1: syndrome and overall parity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
      s1_ch    <= '0;
    end else if (s0_adv) begin
      s1_valid <= 1'b1;
      s1_cw    <= s0_cw;
      s1_syn   <= chk_syn;
      s1_par   <= chk_par;
      s1_ch    <= s0_ch;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: corrected result, held until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid         <= 1'b0;
      bus.out_data     <= '0;
      bus.out_ch       <= '0;
      bus.out_sbe      <= 1'b0;
      bus.out_dbe      <= 1'b0;
      bus.out_syndrome <= '0;
    end else if (s1_adv) begin
      s2_valid         <= 1'b1;
      bus.out_data     <= fix_data;
      bus.out_ch       <= s1_ch;
      bus.out_sbe      <= fix_sbe;
      bus.out_dbe      <= fix_dbe;
      bus.out_syndrome <= s1_syn;
    end else if (out_hs) begin
      s2_valid <= 1'b0;
    end
  end

  // Channel holding registers; uncorrectable words leave the channel untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_data <= '0;
    end else if (out_hs && !bus.out_dbe) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (32'(bus.out_ch) == k) ch_data[k*DATA_W +: DATA_W] <= bus.out_data;
      end
    end
  end

  // Saturating error counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_hs) begin
      if (bus.out_sbe && corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
      if (bus.out_dbe && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_link.sv
// Scoreboard bench for hamming_secded_link: the driver pushes hand-computed
// expected results at each input handshake, a monitor pops and compares them
// at each output handshake.
module tb_hamming_secded_link;
  import hamming_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       ch;
    logic       sbe;
    logic       dbe;
    logic [3:0] syn;
    bit         syn_any;
    bit         chk_lat;
    int         drive_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int accepted = 0;
  exp_t sb[$];
  exp_t mon_e;

  hamming_secded_link_if #(.DATA_W(8), .N_CH(2)) bus ();
  logic [15:0] ch_data;
  logic [7:0]  corr_cnt;
  logic [7:0]  uncorr_cnt;

  hamming_secded_link #(.DATA_W(8), .N_CH(2), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .ch_data    (ch_data),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  hamming_secded_link_if #(.DATA_W(8), .N_CH(2)) bus2 ();
  logic [15:0] ch_data2;
  logic [1:0]  corr2;
  logic [1:0]  uncorr2;

  hamming_secded_link #(.DATA_W(8), .N_CH(2), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus2),
    .ch_data    (ch_data2),
    .corr_cnt   (corr2),
    .uncorr_cnt (uncorr2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic ch, input logic [1:0] mode,
                      input logic [3:0] pos, input logic [7:0] xd, input logic xsbe,
                      input logic xdbe, input logic [3:0] xsyn, input bit syn_any,
                      input bit lat);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_ch    = ch;
    bus.inj_mode = mode;
    bus.inj_pos  = pos;
    #1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bus.in_ready) begin
      e.data      = xd;
      e.ch        = ch;
      e.sbe       = xsbe;
      e.dbe       = xdbe;
      e.syn       = xsyn;
      e.syn_any   = syn_any;
      e.chk_lat   = lat;
      e.drive_cyc = cyc;
      sb.push_back(e);
      accepted++;
    end else begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 for data %0h", d);
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d outstanding expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compares each accepted result against the head of the scoreboard.
  always @(negedge clk) begin
    #1;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0h expected none", bus.out_data);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", 32'(bus.out_data), 32'(mon_e.data));
        check("out_ch", 32'(bus.out_ch), 32'(mon_e.ch));
        check("out_sbe", 32'(bus.out_sbe), 32'(mon_e.sbe));
        check("out_dbe", 32'(bus.out_dbe), 32'(mon_e.dbe));
        if (!mon_e.syn_any) check("out_syndrome", 32'(bus.out_syndrome), 32'(mon_e.syn));
        if (mon_e.chk_lat) check("latency", 32'(cyc - mon_e.drive_cyc), 32'd3);
      end
    end
  end

  initial begin
    int acc0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ch     = '0;
    bus.inj_mode  = '0;
    bus.inj_pos   = '0;
    bus.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.in_ch     = '0;
    bus2.inj_mode  = '0;
    bus2.inj_pos   = '0;
    bus2.out_ready = 1'b1;

    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_ch_data", 32'(ch_data), 32'd0);
    check("rst_corr_cnt", 32'(corr_cnt), 32'd0);
    reset = 1'b0;

    // Clean word.
    send(8'hA5, 1'b0, 2'b00, 4'd0, 8'hA5, 1'b0, 1'b0, 4'd0, 0, 1);
    drain();
    check("ch0_clean", 32'(ch_data[7:0]), 32'h A5);
    check("corr_after_clean", 32'(corr_cnt), 32'd0);

    // Single error at position 5.
    send(8'h3C, 1'b1, 2'b01, 4'd5, 8'h3C, 1'b1, 1'b0, 4'd5, 0, 1);
    drain();
    check("corr_after_sbe", 32'(corr_cnt), 32'd1);
    check("ch1_sbe", 32'(ch_data[15:8]), 32'h3C);

    // Double errors at 3/4 (payload bit0 flipped) and 12/0 (payload bit7 flipped).
    send(8'h3C, 1'b0, 2'b10, 4'd3, 8'h3D, 1'b0, 1'b1, 4'd7, 0, 1);
    drain();
    check("ch0_kept_dbe", 32'(ch_data[7:0]), 32'h A5);
    check("uncorr_1", 32'(uncorr_cnt), 32'd1);
    send(8'h3C, 1'b0, 2'b10, 4'd12, 8'hBC, 1'b0, 1'b1, 4'd12, 0, 1);
    drain();
    check("ch0_kept_wrap", 32'(ch_data[7:0]), 32'h A5);
    check("uncorr_2", 32'(uncorr_cnt), 32'd2);

    // Overall parity bit error, then out-of-range position.
    send(8'hFF, 1'b1, 2'b01, 4'd0, 8'hFF, 1'b1, 1'b0, 4'd0, 0, 1);
    send(8'hFF, 1'b1, 2'b01, 4'd13, 8'hFF, 1'b0, 1'b0, 4'd0, 0, 1);
    drain();
    check("corr_after_p0", 32'(corr_cnt), 32'd2);

    // Highest data position, and free-running position.
    send(8'h5A, 1'b0, 2'b01, 4'd12, 8'h5A, 1'b1, 1'b0, 4'd12, 0, 1);
    send(8'h81, 1'b1, 2'b11, 4'd0, 8'h81, 1'b1, 1'b0, 4'd0, 1, 1);
    drain();
    check("corr_after_free", 32'(corr_cnt), 32'd4);
    check("ch_after_free", 32'(ch_data), 32'h815A);

    // Back-pressure: consumer stalls for 6 cycles while 5 words are offered.
    acc0 = accepted;
    bus.out_ready = 1'b0;
    fork
      begin
        send(8'h11, 1'b0, 2'b00, 4'd0, 8'h11, 1'b0, 1'b0, 4'd0, 0, 0);
        send(8'h22, 1'b1, 2'b00, 4'd0, 8'h22, 1'b0, 1'b0, 4'd0, 0, 0);
        send(8'h33, 1'b0, 2'b00, 4'd0, 8'h33, 1'b0, 1'b0, 4'd0, 0, 0);
        send(8'h44, 1'b1, 2'b00, 4'd0, 8'h44, 1'b0, 1'b0, 4'd0, 0, 0);
        send(8'h55, 1'b0, 2'b00, 4'd0, 8'h55, 1'b0, 1'b0, 4'd0, 0, 0);
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_accepted", 32'(accepted - acc0), 32'd3);
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("ch_after_bp", 32'(ch_data), 32'h4455);

    // Asynchronous reset with words in flight.
    send(8'h12, 1'b0, 2'b00, 4'd0, 8'h12, 1'b0, 1'b0, 4'd0, 0, 1);
    send(8'h34, 1'b1, 2'b01, 4'd2, 8'h34, 1'b1, 1'b0, 4'd2, 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_corr_cnt", 32'(corr_cnt), 32'd0);
    check("arst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    check("arst_ch_data", 32'(ch_data), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    send(8'h96, 1'b1, 2'b00, 4'd0, 8'h96, 1'b0, 1'b0, 4'd0, 0, 1);
    drain();
    check("ch_after_reset", 32'(ch_data), 32'h9600);

    // Saturation of a 2-bit counter with 5 corrected words.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus2.in_valid = 1'b1;
      bus2.in_data  = 8'(i * 16 + 3);
      bus2.in_ch    = 1'b0;
      bus2.inj_mode = 2'b01;
      bus2.inj_pos  = 4'(i + 1);
    end
    @(negedge clk);
    bus2.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("sat_corr_cnt", 32'(corr2), 32'd3);
    check("sat_uncorr_cnt", 32'(uncorr2), 32'd0);
    check("sat_ch0", 32'(ch_data2[7:0]), 32'h43);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
